// File: rtl/if_id_stage_reg_pkg.sv
// Shared front-end constants and the IF/ID control state type.
package if_id_stage_reg_pkg;

  // Instruction encoding that decode treats as a no-operation.
  localparam logic [15:0] CORE_NOP_INST = 16'h0800;

  // Opcode field [15:11] value that identifies HALT.
  localparam logic [4:0]  CORE_HALT_OPC = 5'b00000;

  // IF/ID control state.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_WAIT = 2'd1,
    HALTED    = 2'd2
  } state_e;

  // True when the instruction's opcode field matches the HALT opcode.
  function automatic logic is_halt(input logic [15:0] inst, input logic [4:0] halt_opc);
    return inst[15:11] == halt_opc;
  endfunction

endpackage

// File: rtl/if_id_stage_reg_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count up on inc until all-ones; clr and rst return to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: latches fetched instruction and PC+2, freezes on
// RAW hazards, inserts NOPs on flush or I-mem miss, parks on HALT and counts
// hazard-stall cycles.
//
// Handshake: there is no valid/ready pair here. valid_out marks inst_out as a
// real instruction; pc_write_en is the upstream "may advance" and bubble_out
// tells ID/EX to take a NOP this cycle. Both are combinational from the
// current inputs and state, register updates land one cycle later.
module if_id_stage_reg
  import if_id_stage_reg_pkg::*;
#(
  parameter logic [15:0] NOP_INST = CORE_NOP_INST,
  parameter logic [4:0]  HALT_OPC = CORE_HALT_OPC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      inst_in,
  input  logic [15:0]      pc_plus2_in,
  input  logic             inst_valid_in,
  input  logic             raw_stall,
  input  logic             flush,
  output logic [15:0]      inst_out,
  output logic [15:0]      pc_plus2_out,
  output logic             valid_out,
  output logic             pc_write_en,
  output logic             bubble_out,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output state_e           state_dbg
);

  state_e state_q;
  state_e state_d;
  logic   load_en;
  logic   nop_en;
  logic   stall_inc;

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Event priority: flush > HALTED park > raw_stall > miss > normal load.
  always_comb begin
    state_d     = state_q;
    pc_write_en = 1'b0;
    bubble_out  = 1'b0;
    load_en     = 1'b0;
    nop_en      = 1'b0;
    stall_inc   = 1'b0;
    if (rst) begin
      bubble_out = 1'b1;
    end else if (flush) begin
      // The flushing branch owns ID/EX, so no bubble; redirected PC loads.
      pc_write_en = 1'b1;
      nop_en      = 1'b1;
      state_d     = RUN;
    end else if (state_q == HALTED) begin
      // Parked: hazards belong to nothing live, so they are neither honoured nor counted.
    end else if (raw_stall) begin
      bubble_out = 1'b1;
      stall_inc  = 1'b1;
    end else if (!inst_valid_in) begin
      nop_en  = 1'b1;
      state_d = MISS_WAIT;
    end else begin
      pc_write_en = 1'b1;
      load_en     = 1'b1;
      state_d     = is_halt(inst_in, HALT_OPC) ? HALTED : RUN;
    end
  end

  // Instruction / PC+2 register; PC+2 is kept when a NOP is injected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_out     <= NOP_INST;
      pc_plus2_out <= '0;
      valid_out    <= 1'b0;
    end else if (nop_en) begin
      inst_out     <= NOP_INST;
      valid_out    <= 1'b0;
    end else if (load_en) begin
      inst_out     <= inst_in;
      pc_plus2_out <= pc_plus2_in;
      valid_out    <= 1'b1;
    end
  end

  // Halt indication and debug state view.
  always_comb begin
    halted    = (state_q == HALTED) && !rst;
    state_dbg = state_q;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clr   (1'b0),
    .count (stall_count)
  );

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Self-checking bench for if_id_stage_reg: directed plan, then random traffic
// against a behavioural model; a narrow-counter instance exercises saturation.
module tb_if_id_stage_reg;
  import if_id_stage_reg_pkg::*;

  localparam int SMALL_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] inst_in, pc_plus2_in;
  logic        inst_valid_in, raw_stall, flush;

  logic [15:0] inst_out, pc_plus2_out;
  logic        valid_out, pc_write_en, bubble_out, halted;
  logic [15:0] stall_count;
  state_e      state_dbg;

  logic [15:0]        s_inst_out, s_pc_plus2_out;
  logic               s_valid_out, s_pc_write_en, s_bubble_out, s_halted;
  logic [SMALL_W-1:0] s_stall_count;
  state_e             s_state_dbg;

  if_id_stage_reg dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .pc_plus2_in(pc_plus2_in),
    .inst_valid_in(inst_valid_in), .raw_stall(raw_stall), .flush(flush),
    .inst_out(inst_out), .pc_plus2_out(pc_plus2_out), .valid_out(valid_out),
    .pc_write_en(pc_write_en), .bubble_out(bubble_out), .halted(halted),
    .stall_count(stall_count), .state_dbg(state_dbg)
  );

  if_id_stage_reg #(.CNT_W(SMALL_W)) dut_small (
    .clk(clk), .rst(rst), .inst_in(inst_in), .pc_plus2_in(pc_plus2_in),
    .inst_valid_in(inst_valid_in), .raw_stall(raw_stall), .flush(flush),
    .inst_out(s_inst_out), .pc_plus2_out(s_pc_plus2_out), .valid_out(s_valid_out),
    .pc_write_en(s_pc_write_en), .bubble_out(s_bubble_out), .halted(s_halted),
    .stall_count(s_stall_count), .state_dbg(s_state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_inst, m_pc2;
  bit          m_valid, m_halted, m_miss;
  int          m_stalls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input int n, input int w);
    int max_v;
    max_v = (1 << w) - 1;
    return (n > max_v) ? max_v : n;
  endfunction

  task automatic model_reset();
    m_inst = 16'h0800; m_pc2 = 16'h0000; m_valid = 0;
    m_halted = 0; m_miss = 0; m_stalls = 0;
  endtask

  task automatic check_reset();
    check("rst_inst",   inst_out,      32'h0800);
    check("rst_pc2",    pc_plus2_out,  32'h0);
    check("rst_valid",  valid_out,     32'h0);
    check("rst_pcwe",   pc_write_en,   32'h0);
    check("rst_bubble", bubble_out,    32'h1);
    check("rst_halted", halted,        32'h0);
    check("rst_cnt",    stall_count,   32'h0);
    check("rst_cnt_s",  s_stall_count, 32'h0);
    check("rst_state",  32'(state_dbg), 32'(RUN));
  endtask

  // Compare all outputs with the model for the inputs now applied.
  task automatic check_outputs();
    bit exp_pcwe, exp_bubble;
    state_e exp_state;
    if (flush)         begin exp_pcwe = 1; exp_bubble = 0; end
    else if (m_halted) begin exp_pcwe = 0; exp_bubble = 0; end
    else if (raw_stall) begin exp_pcwe = 0; exp_bubble = 1; end
    else               begin exp_pcwe = inst_valid_in; exp_bubble = 0; end
    exp_state = m_halted ? HALTED : (m_miss ? MISS_WAIT : RUN);
    check("inst",   inst_out,  m_inst);
    check("valid",  valid_out, m_valid);
    if (m_valid) check("pc2", pc_plus2_out, m_pc2);
    check("pcwe",   pc_write_en, exp_pcwe);
    check("bubble", bubble_out,  exp_bubble);
    check("halted", halted,      m_halted);
    check("state",  32'(state_dbg), 32'(exp_state));
    check("cnt",    stall_count,   sat(m_stalls, 16));
    check("cnt_s",  s_stall_count, sat(m_stalls, SMALL_W));
  endtask

  task automatic model_update(input logic [15:0] i, input logic [15:0] p,
                              input bit iv, input bit rs, input bit fl);
    if (fl) begin
      m_inst = 16'h0800; m_valid = 0; m_halted = 0; m_miss = 0;
    end else if (m_halted) begin
      // parked
    end else if (rs) begin
      m_stalls++;
    end else if (!iv) begin
      m_inst = 16'h0800; m_valid = 0; m_miss = 1;
    end else begin
      m_inst = i; m_pc2 = p; m_valid = 1; m_miss = 0;
      m_halted = (i[15:11] == 5'b00000);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [15:0] i, input logic [15:0] p,
                      input bit iv, input bit rs, input bit fl);
    inst_in = i; pc_plus2_in = p; inst_valid_in = iv; raw_stall = rs; flush = fl;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update(i, p, iv, rs, fl);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    inst_in = '0; pc_plus2_in = '0; inst_valid_in = 0; raw_stall = 0; flush = 0;
    model_reset();
    #3;
    check_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // First load
    step(16'hC0A4, 16'h0002, 1, 0, 0);
    // Three hazard cycles while fetch presents the next instruction
    repeat (3) step(16'hD8E0, 16'h0004, 1, 1, 0);
    step(16'hD8E0, 16'h0004, 1, 0, 0);
    // Flush and stall together: flush wins, no count
    step(16'h1234, 16'h0006, 1, 1, 1);
    // Two miss cycles, then a real instruction
    repeat (2) step(16'hABCD, 16'h0008, 0, 0, 0);
    step(16'h4123, 16'h0008, 1, 0, 0);
    // HALT, held through stalls, released by flush
    step(16'h0000, 16'h000A, 1, 0, 0);
    repeat (5) step(16'h5555, 16'h000C, 1, 1, 0);
    step(16'h5555, 16'h000C, 1, 0, 1);
    step(16'h2222, 16'h000E, 1, 0, 0);
    // Long stall run: narrow counter saturates at all-ones
    repeat (10) step(16'h3333, 16'h0010, 1, 1, 0);
    step(16'h3333, 16'h0010, 1, 0, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ri;
      ri = 16'($urandom);
      if ($urandom_range(0, 15) == 0) ri[15:11] = 5'b00000;
      step(ri, 16'($urandom),
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset in the middle of a stall
    step(16'h7777, 16'h0020, 1, 0, 1);
    step(16'h7777, 16'h0020, 1, 0, 0);
    inst_in = 16'h8888; pc_plus2_in = 16'h0022; inst_valid_in = 1;
    raw_stall = 1; flush = 0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(16'h9ABC, 16'h0024, 1, 0, 0);
    step(16'h9ABC, 16'h0024, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage_reg.md
Name: if_id_stage_reg

Overview:
- IF/ID pipeline register for the 16-bit five-stage core. It sits directly downstream of the RAW hazard checker and consumes the checker's aggregated stall.
- Holds the fetched instruction and PC+2, and freezes both PC and IF/ID while a RAW hazard is pending.
- Injects a NOP into ID on a branch flush or an instruction-memory miss, and parks the front end on HALT.
- Keeps a saturating count of hazard-stall cycles for performance debug.

Parameters:
- NOP_INST, 16'h0800, encoding loaded into the register when the slot is empty.
- HALT_OPC, 5'b00000, opcode field [15:11] that identifies HALT.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_in  in  16  instruction from fetch.
- pc_plus2_in  in  16  PC+2 of the fetched instruction.
- inst_valid_in  in  1  instruction memory returned inst_in this cycle (0 = miss/busy).
- raw_stall  in  1  OR of RAW checks of ID against ID/EX, EX/MEM and MEM/WB.
- flush  in  1  taken branch/jump resolved downstream; the younger instruction is wrong-path.
- inst_out  out  16  instruction presented to decode.
- pc_plus2_out  out  16  PC+2 presented to decode.
- valid_out  out  1  inst_out is a real instruction.
- pc_write_en  out  1  PC register may advance this cycle.
- bubble_out  out  1  ID/EX must load a NOP/control-zero this cycle.
- halted  out  1  front end parked on a valid HALT.
- stall_count  out  CNT_W  saturating count of raw_stall cycles.

Behaviour:
- Reset (asynchronous, on rst=1):
  - inst_out=NOP_INST, pc_plus2_out=0, valid_out=0, stall_count=0, state=RUN.
  - Combinational outputs while in reset: pc_write_en=0, bubble_out=1, halted=0.
- States: RUN, MISS_WAIT, HALTED. Event priority each cycle: flush > raw_stall > miss (inst_valid_in=0) > normal load.
- flush (any state):
  - Next cycle: inst_out=NOP_INST, valid_out=0, state=RUN.
  - pc_write_en=1 so the redirected PC loads.
  - bubble_out=0. The flushing branch owns ID/EX.
  - Not counted as a stall.
- raw_stall=1 (no flush, state RUN or MISS_WAIT):
  - inst_out, pc_plus2_out, valid_out and state all hold.
  - pc_write_en=0, bubble_out=1.
  - stall_count+1, saturating at all-ones.
  - raw_stall when valid_out=0 is still honoured and still counted.
- Miss (RUN or MISS_WAIT, no flush, no raw_stall, inst_valid_in=0):
  - Load NOP_INST, valid_out=0, pc_write_en=0, bubble_out=0.
  - Next state MISS_WAIT. Any cycle with inst_valid_in=1 returns to a normal load.
- Normal load:
  - inst_out<=inst_in, pc_plus2_out<=pc_plus2_in, valid_out<=1.
  - pc_write_en=1, bubble_out=0.
  - If inst_in[15:11]==HALT_OPC, the next state is HALTED, else RUN.
- HALTED:
  - Register holds, pc_write_en=0, bubble_out=0, halted=1.
  - raw_stall is ignored in this state and not counted.
  - Only flush (older branch proves HALT wrong-path) or rst leaves HALTED.
- halted is combinational from state (HALTED & ~rst). There is no extra latency.
- pc_write_en and bubble_out are combinational from the current inputs and state. Register updates take effect with latency of one cycle.
- Simultaneous flush and raw_stall: flush wins; the stale hazard belongs to a squashed instruction.
- Reset mid-stall or mid-miss: immediate return to reset values. The counter clears.

Decomposition:
- Shared core package holds:
  - NOP and HALT opcode constants, reused by decode and the hazard checker.
  - State enum {RUN, MISS_WAIT, HALTED}.
- One sub-module, sat_counter (CNT_W wide, inc and clr inputs, saturates at all-ones), used for stall_count. Everything else is inline.

Test Plan:
- Reset, then inst_in=16'hC0A4, pc_plus2_in=16'h0002, inst_valid_in=1 → next cycle inst_out=16'hC0A4, pc_plus2_out=2, valid_out=1, pc_write_en=1.
- With 16'hC0A4 latched, raw_stall=1 for 3 cycles while inst_in changes to 16'hD8E0 → inst_out remains 16'hC0A4, pc_write_en=0 and bubble_out=1 for all 3 cycles, stall_count=3. On release, 16'hD8E0 loads.
- raw_stall=1 and flush=1 in the same cycle → next inst_out=16'h0800, valid_out=0, pc_write_en=1, bubble_out=0, stall_count unchanged.
- inst_valid_in=0 for 2 cycles → state MISS_WAIT, inst_out=16'h0800, valid_out=0, pc_write_en=0. inst_valid_in=1 with 16'h4123 → 16'h4123 latched, state RUN.
- Load 16'h0000 (HALT) → halted=1 and pc_write_en=0 persist over 5 cycles despite raw_stall=1, with no counting. flush=1 → halted=0, inst_out=16'h0800, state RUN.
- Preload stall_count to 16'hFFFE via 2 forced cycles, then 3 raw_stall cycles → stall_count saturates at 16'hFFFF. Assert rst mid-stall → all outputs return to their reset values asynchronously.
